// File: rtl/muldiv32.sv
// muldiv32: HI/LO multiply/divide unit for a MIPS-style integer pipeline.
// Iterative radix-2 shift-add multiply and restoring divide, one bit per cycle,
// followed by a single sign-fixup cycle that commits HI/LO.
// Build option: define MULDIV_FAST_MUL_EN to compute mult/multu in one step
// (IDLE -> FIXUP) instead of iterating; divide is unaffected.
//
// state | meaning
// IDLE  | waiting for Start; mthi/mtlo write HI/LO directly
// RUN   | one product/quotient bit per cycle, counter 0..31
// FIXUP | apply result/remainder signs, write HI/LO, pulse Done
module muldiv32 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] Read_data_1,
  input  logic [31:0] Read_data_2,
  input  logic [5:0]  Function_opcode,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MF_Result
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] FIXUP = 2'b10;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [63:0] acc;       // multiply: {partial product, multiplier}; divide: {remainder, quotient}
  logic [31:0] b_mag;     // multiplicand or divisor magnitude
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;

  logic        op_mul;
  logic        op_div;
  logic        op_signed;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_diff;
  logic [63:0] acc_step;
  logic [63:0] neg_acc;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;
`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] rs_ext;
  logic [63:0] rt_ext;
  logic [63:0] fast_prod;
`endif

  // Decode the funct field and form operand magnitudes for a new operation
  always_comb begin
    op_mul    = (Function_opcode == F_MULT) || (Function_opcode == F_MULTU);
    op_div    = (Function_opcode == F_DIV)  || (Function_opcode == F_DIVU);
    op_signed = (Function_opcode == F_MULT) || (Function_opcode == F_DIV);
    rs_neg    = op_signed & Read_data_1[31];
    rt_neg    = op_signed & Read_data_2[31];
    rs_mag    = rs_neg ? (~Read_data_1 + 32'd1) : Read_data_1;
    rt_mag    = rt_neg ? (~Read_data_2 + 32'd1) : Read_data_2;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-step product: sign-extend for mult, zero-extend for multu
  always_comb begin
    rs_ext    = {{32{rs_neg}}, Read_data_1};
    rt_ext    = {{32{rt_neg}}, Read_data_2};
    fast_prod = rs_ext * rt_ext;
  end
`endif

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
    div_diff = acc[63:31] - {1'b0, b_mag};
    if (is_div) begin
      if (div_diff[32]) acc_step = {acc[62:0], 1'b0};
      else              acc_step = {div_diff[31:0], acc[30:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[31:1]};
    end
  end

  // Sign fixup of the finished magnitude result
  always_comb begin
    neg_acc = ~acc + 64'd1;
    fix_hi  = acc[63:32];
    fix_lo  = acc[31:0];
    if (is_div) begin
      if (neg_res) fix_lo = ~acc[31:0] + 32'd1;
      if (neg_rem) fix_hi = ~acc[63:32] + 32'd1;
    end else if (neg_res) begin
      fix_hi = neg_acc[63:32];
      fix_lo = neg_acc[31:0];
    end
  end

  // mfhi/mflo read path, independent of Start
  always_comb begin
    MF_Result = 32'd0;
    if (Function_opcode == F_MFHI)      MF_Result = HI;
    else if (Function_opcode == F_MFLO) MF_Result = LO;
  end

  // Sequencer: accepts work in IDLE only, so Start while busy is dropped
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      acc     <= 64'd0;
      b_mag   <= 32'd0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (Function_opcode == F_MTHI) HI <= Read_data_1;
            if (Function_opcode == F_MTLO) LO <= Read_data_1;
            if (op_mul || op_div) begin
              b_mag  <= rt_mag;
              is_div <= op_div;
              cnt    <= 6'd0;
              Busy   <= 1'b1;
              if (op_div && (Read_data_2 == 32'd0)) begin
                // divide by zero: fixed pattern, raw dividend to HI, no signs
                acc     <= {Read_data_1, 32'hFFFF_FFFF};
                neg_res <= 1'b0;
                neg_rem <= 1'b0;
                state   <= FIXUP;
              end
`ifdef MULDIV_FAST_MUL_EN
              else if (op_mul) begin
                acc     <= fast_prod;
                neg_res <= 1'b0;
                neg_rem <= 1'b0;
                state   <= FIXUP;
              end
`endif
              else begin
                acc     <= {32'd0, rs_mag};
                neg_res <= rs_neg ^ rt_neg;
                neg_rem <= rs_neg;
                state   <= RUN;
              end
            end
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIXUP;
        end
        FIXUP: begin
          HI    <= fix_hi;
          LO    <= fix_lo;
          Done  <= 1'b1;
          Busy  <= 1'b0;
          cnt   <= 6'd0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv32.sv
// tb_muldiv32: directed scoreboard bench for muldiv32.
// Latency is counted in rising edges, the Start sampling edge being edge 1.
module tb_muldiv32;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam int LAT_DIV = 34;
  localparam int LAT_SHORT = 2;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 2;
`else
  localparam int LAT_MUL = 34;
`endif

  logic        clock;
  logic        reset_n;
  logic [31:0] Read_data_1;
  logic [31:0] Read_data_2;
  logic [5:0]  Function_opcode;
  logic        Start;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MF_Result;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  muldiv32 dut (
    .clock(clock), .reset_n(reset_n), .Read_data_1(Read_data_1),
    .Read_data_2(Read_data_2), .Function_opcode(Function_opcode), .Start(Start),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO), .MF_Result(MF_Result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb_l, p;
    logic [63:0] up;
    int          ia, ib;
    e.lat = (f == F_MULT || f == F_MULTU) ? LAT_MUL : LAT_DIV;
    case (f)
      F_MULT: begin
        sa = longint'($signed(a)); sb_l = longint'($signed(b)); p = sa * sb_l;
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      F_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        e.hi = up[63:32]; e.lo = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.lat = LAT_SHORT;
        end else if (f == F_DIVU) begin
          e.lo = a / b; e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 32'd0;
        end else begin
          ia = a; ib = b;
          e.lo = ia / ib; e.hi = ia % ib;
        end
      end
    endcase
    return e;
  endfunction

  // Issue one arithmetic op; optionally inject ignored Starts and MF reads while busy
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    exp_t e;
    int   lat;
    bit   got, busy_ok, done_late;
    sb.push_back(model(f, a, b));
    @(negedge clock);
    Function_opcode = f; Read_data_1 = a; Read_data_2 = b; Start = 1'b1;
    @(posedge clock); #1;
    Start = 1'b0; Function_opcode = 6'h00;
    lat = 1; got = 0; busy_ok = 1;
    while (!got && lat < 100) begin
      if (!Busy) busy_ok = 0;
      if (inject && lat == 5) begin
        Function_opcode = F_MULT; Read_data_1 = 32'h0000_0005; Read_data_2 = 32'h0000_0003; Start = 1'b1;
      end
      if (inject && lat == 6) begin
        Function_opcode = F_MTHI; Read_data_1 = 32'hDEAD_BEEF;
      end
      if (inject && lat == 7) begin
        Start = 1'b0; Function_opcode = F_MFHI;
      end
      if (inject && lat == 8) begin
        check({tag, " mfhi_busy"}, {32'd0, MF_Result}, {32'd0, m_hi});
        Function_opcode = F_MFLO;
      end
      if (inject && lat == 9) begin
        check({tag, " mflo_busy"}, {32'd0, MF_Result}, {32'd0, m_lo});
        Function_opcode = 6'h00;
      end
      @(posedge clock); #1;
      lat++;
      if (Done) got = 1;
    end
    e = sb.pop_front();
    check({tag, " busy_during"}, {63'd0, busy_ok}, 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(e.lat));
    check({tag, " busy_after"}, {63'd0, Busy}, 64'd0);
    check({tag, " hi_lo"}, {HI, LO}, {e.hi, e.lo});
    m_hi = e.hi; m_lo = e.lo;
    @(posedge clock); #1;
    done_late = Done;
    check({tag, " done_pulse"}, {63'd0, done_late}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          seen_done;
    reset_n = 1'b0; Start = 1'b0; Function_opcode = 6'h00;
    Read_data_1 = 32'd0; Read_data_2 = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check("reset state", {HI, LO}, 64'd0);
    check("reset busy_done", {62'd0, Busy, Done}, 64'd0);
    @(posedge clock); #2 reset_n = 1'b1;

    run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max const", {m_hi, m_lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 0);
    check("mult_neg const", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    check("div_neg const", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 0);
    check("divu const", {m_hi, m_lo}, {32'd2, 32'd14});
    run_op("divu_by0", F_DIVU, 32'h1234_5678, 32'd0, 0);
    run_op("div_by0_neg", F_DIV, 32'hFFFF_FFFB, 32'd0, 0);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("mult_minmin", F_MULT, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("div_pos_neg", F_DIV, 32'd100, 32'hFFFF_FFF9, 0);
    run_op("div_neg_pos", F_DIV, 32'hFFFF_FF9C, 32'd7, 0);
    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      run_op("rnd_mult", F_MULT, ra, rb, 0);
      run_op("rnd_multu", F_MULTU, ra, rb, 0);
      run_op("rnd_div", F_DIV, ra, rb >> (i * 8), 0);
      run_op("rnd_divu", F_DIVU, ra, rb >> (i * 9), 0);
    end

    // mthi/mtlo: immediate write, no Busy, no Done
    @(negedge clock);
    Function_opcode = F_MTHI; Read_data_1 = 32'hCAFE_BABE; Start = 1'b1;
    @(posedge clock); #1;
    Start = 1'b0; Function_opcode = F_MFHI;
    #1;
    check("mthi mf_result", {32'd0, MF_Result}, {32'd0, 32'hCAFE_BABE});
    check("mthi busy_done", {62'd0, Busy, Done}, 64'd0);
    m_hi = 32'hCAFE_BABE;
    @(negedge clock);
    Function_opcode = F_MTLO; Read_data_1 = 32'h0BAD_F00D; Start = 1'b1;
    @(posedge clock); #1;
    Start = 1'b0; Function_opcode = F_MFLO;
    #1;
    check("mtlo mf_result", {32'd0, MF_Result}, {32'd0, 32'h0BAD_F00D});
    check("mtlo hi_kept", {32'd0, HI}, {32'd0, 32'hCAFE_BABE});
    m_lo = 32'h0BAD_F00D;
    Function_opcode = 6'h20;
    #1;
    check("mf other funct", {32'd0, MF_Result}, 64'd0);
    @(posedge clock); #1;
    check("mt no done", {63'd0, Done}, 64'd0);

    // Start and mthi while busy are ignored; MF shows old HI/LO
    run_op("busy_ignore", F_MULTU, 32'h0001_0000, 32'h0003_0000, 1);

    // Reset in the middle of an operation discards it
    @(negedge clock);
    Function_opcode = F_MULT; Read_data_1 = 32'h0000_1234; Read_data_2 = 32'h0000_5678; Start = 1'b1;
    @(posedge clock); #1;
    Start = 1'b0; Function_opcode = 6'h00;
    repeat (10) @(posedge clock);
    #1;
    check("pre_reset busy", {63'd0, Busy}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort busy_done", {62'd0, Busy, Done}, 64'd0);
    check("abort hi_lo", {HI, LO}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(posedge clock); #2 reset_n = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (Done || Busy) seen_done = 1;
    end
    check("abort no_late_result", {seen_done, HI, LO}, 65'd0);

    // First Start on the first edge after reset release
    @(posedge clock); reset_n = 1'b0;
    #2 reset_n = 1'b1;
    run_op("post_reset", F_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
